mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
Control FSM for the shift-add multiplier datapath. It sequences operand load, accumulator clear, conditional add and shift over WIDTH iterations. It uses its own internal iteration counter, replacing the free-running 31-count scheme. The datapath convention is acc += mcand; mcand <<= 1; mplier >>= 1. The block sits between the CPU execute stage (Start/Done handshake) and the multiplier registers.

Parameters:
WIDTH, 16, multiplier operand width in bits = number of iterations.
CNT_W, 8, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
Clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
Start  input  1  request; sampled only in IDLE.
Abort  input  1  synchronous cancel; returns to IDLE from any state.
Lsb  input  1  current multiplier LSB from datapath.
MulZero  input  1  datapath multiplier register == 0; used only with EARLY_EXIT_EN.
LoadRegs  output  1  load operand registers.
ClearAcc  output  1  clear accumulator.
AddEn  output  1  acc <= acc + mcand.
ShiftEn  output  1  mcand << 1, mplier >> 1.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle completion pulse.
Iter  output  CNT_W  iterations completed in the current operation.

Behaviour:
- Reset is asynchronous, active-high, clock Clk. On reset: state=IDLE, Iter=0, and all outputs are 0.
- Outputs are Moore, decoded from the state register only. No input-to-output combinational path.
- States and transitions:
  - IDLE: all outputs 0. Start=1 and Abort=0 -> LOAD. Otherwise stay.
  - LOAD: LoadRegs=1, ClearAcc=1, Iter cleared to 0. Next state is CHECK.
  - CHECK: no strobes. Lsb=1 -> ADD; Lsb=0 -> SHIFT.
  - ADD: AddEn=1. Next state is SHIFT.
  - SHIFT: ShiftEn=1, Iter increments. If Iter == WIDTH-1 before the increment -> DONE; else -> CHECK.
  - DONE: Done=1 for exactly one cycle. Iter holds WIDTH. Next state is IDLE.
- Latency: Start is sampled at edge 0. LOAD occupies cycle 1. Each bit takes 2 cycles, plus 1 if the bit is 1. Done is high in cycle 2+2*WIDTH+P, where P = popcount(multiplier).
- Start while Busy is ignored. There is no queuing.
- Abort has priority over every transition. The next state is IDLE, Iter is cleared, and Done is not asserted.
- Start and Abort high together in IDLE: remain in IDLE.
- Start held high continuously: a new operation starts from the IDLE cycle that follows DONE. Minimum spacing between operations is one IDLE cycle.
- Iter holds its value in IDLE until the next LOAD or Abort.
- Mid-operation rst: immediate return to the IDLE reset values, with no Done.
- Unused state encodings recover to IDLE on the next edge.

Optional Feature:
EARLY_EXIT_EN
- Defined: in CHECK, MulZero=1 -> DONE directly, with no further ADD/SHIFT. Iter reports the iterations actually performed. This is valid because mplier shifts right and mcand shifts left.
- Undefined: MulZero is ignored and exactly WIDTH iterations always run.

Decomposition:
- Package mult_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, ADD, SHIFT, DONE) with a fixed 3-bit encoding;
  - the localparam for the default WIDTH;
  - a function computing the minimum CNT_W.
- Sub-module mult_iter_counter holds the iteration counter. Interface: clear, inc, terminal flag at WIDTH-1, count out. The FSM stays in mult_seq_ctrl.

Test Plan:
- Reset mid-SHIFT with WIDTH=4 -> all outputs 0 and state IDLE immediately, Iter=0, no Done.
- WIDTH=4, multiplier 4'b1011, Start pulse at edge 0 -> LoadRegs in cycle 1; AddEn in three cycles; ShiftEn in four; Done in cycle 13; Iter=4.
- WIDTH=4, multiplier 0, feature undefined -> no AddEn, four ShiftEn, Done in cycle 10.
- Same as above with EARLY_EXIT_EN and MulZero=1 from LOAD onward -> Done in cycle 3, Iter=0, no ShiftEn.
- Start re-pulsed while Busy, then Abort in the 2nd CHECK -> second Start ignored; IDLE next cycle; no Done; Busy=0.
- Start held high for 30 cycles, WIDTH=4, multiplier 4'b1111 -> first Done in cycle 14, then exactly one IDLE cycle, then LoadRegs again.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg
// Shared definitions for the shift-add multiplier control slice:
//   - state_t : FSM state enum with a fixed 3-bit encoding
//   - DEFAULT_WIDTH : default multiplier operand width (iterations)
//   - min_cnt_w() : smallest iteration-counter width able to hold WIDTH
package mult_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    // The counter must reach WIDTH itself (value shown in DONE),
    // so it needs 2**w > WIDTH.
    function automatic int min_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// mult_iter_counter
// Iteration counter for the shift-add multiplier sequencer.
// Ports:
//   Clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (count -> 0)
//   clear in   synchronous clear (priority over inc)
//   inc   in   advance count by one
//   term  out  count == WIDTH-1 (the current SHIFT is the last one)
//   count out  iterations completed, CNT_W bits
module mult_iter_counter
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic             term,
    output logic [CNT_W-1:0] count
);

    if (CNT_W < min_cnt_w(WIDTH)) begin : g_cnt_w_check
        $error("mult_iter_counter: CNT_W too small for WIDTH");
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign term = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
// Control FSM for a shift-add multiplier (acc += mcand; mcand <<= 1;
// mplier >>= 1). Runs WIDTH iterations of CHECK -> [ADD] -> SHIFT after a
// LOAD, then pulses Done for one cycle. All outputs are Moore decodes of
// the state register; Iter comes straight from the counter register.
// Build option: define EARLY_EXIT_EN to finish as soon as the multiplier
// register reaches zero (MulZero seen in CHECK); otherwise MulZero is ignored.
// Ports:
//   Clk, rst      clock (rising) / asynchronous active-high reset
//   Start         request, only honoured in IDLE
//   Abort         synchronous cancel from any state, highest priority
//   Lsb, MulZero  multiplier register status from the datapath
//   LoadRegs, ClearAcc, AddEn, ShiftEn  datapath strobes
//   Busy          high outside IDLE
//   Done          one-cycle completion pulse
//   Iter          iterations completed in the current operation
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Lsb,
    input  logic             MulZero,
    output logic             LoadRegs,
    output logic             ClearAcc,
    output logic             AddEn,
    output logic             ShiftEn,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Iter
);

    state_t state_q;
    state_t state_nxt;
    logic   cnt_clear;
    logic   cnt_inc;
    logic   cnt_term;

`ifndef EARLY_EXIT_EN
    logic unused_mulzero;
    assign unused_mulzero = MulZero;
`endif

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        LoadRegs  = 1'b0;
        ClearAcc  = 1'b0;
        AddEn     = 1'b0;
        ShiftEn   = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;

        case (state_q)
            IDLE: begin
                Busy = 1'b0;
                if (Start) state_nxt = LOAD;
            end
            LOAD: begin
                LoadRegs  = 1'b1;
                ClearAcc  = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
`ifdef EARLY_EXIT_EN
                // Remaining multiplier bits are all zero: nothing left to add.
                if (MulZero)  state_nxt = DONE;
                else if (Lsb) state_nxt = ADD;
                else          state_nxt = SHIFT;
`else
                if (Lsb) state_nxt = ADD;
                else     state_nxt = SHIFT;
`endif
            end
            ADD: begin
                AddEn     = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ShiftEn   = 1'b1;
                state_nxt = cnt_term ? DONE : CHECK;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                Busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides every transition, including IDLE -> LOAD.
        if (Abort) state_nxt = IDLE;
    end

    // Counter is cleared while in LOAD (so it reads 0 from the first CHECK)
    // and on Abort; otherwise it holds, which keeps Iter stable in IDLE.
    assign cnt_clear = Abort || (state_q == LOAD);
    assign cnt_inc   = (state_q == SHIFT);

    mult_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .Clk   (Clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .term  (cnt_term),
        .count (Iter)
    );

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl
// Directed bench for mult_seq_ctrl with WIDTH=4. A small multiplier-register
// model supplies Lsb/MulZero from LoadRegs/ShiftEn. Cycle c is the period
// after clock edge c-1, where edge 0 samples Start; outputs are sampled on
// the falling edge.
module tb_mult_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             Clk = 1'b0;
    logic             rst;
    logic             Start;
    logic             Abort;
    logic             Lsb;
    logic             MulZero;
    logic             LoadRegs;
    logic             ClearAcc;
    logic             AddEn;
    logic             ShiftEn;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Iter;

    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mreg;

    int vectors    = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    mult_seq_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk      (Clk),
        .rst      (rst),
        .Start    (Start),
        .Abort    (Abort),
        .Lsb      (Lsb),
        .MulZero  (MulZero),
        .LoadRegs (LoadRegs),
        .ClearAcc (ClearAcc),
        .AddEn    (AddEn),
        .ShiftEn  (ShiftEn),
        .Busy     (Busy),
        .Done     (Done),
        .Iter     (Iter)
    );

    // Datapath multiplier register.
    always @(posedge Clk or posedge rst) begin
        if (rst)           mreg <= '0;
        else if (LoadRegs) mreg <= mplier;
        else if (ShiftEn)  mreg <= mreg >> 1;
    end
    assign Lsb     = mreg[0];
    assign MulZero = (mreg == '0);

    task automatic chk_vec(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_word();
        return {LoadRegs, ClearAcc, AddEn, ShiftEn, Busy, Done};
    endfunction

    // Pulse Start for edge 0, then watch up to max_cyc cycles for Done.
    task automatic run_op(input logic [WIDTH-1:0] mp, input int max_cyc,
                          output int load_cyc, output int done_cyc,
                          output int n_add, output int n_shift,
                          output int iter_done);
        load_cyc  = -1;
        done_cyc  = -1;
        n_add     = 0;
        n_shift   = 0;
        iter_done = -1;
        @(negedge Clk);
        mplier = mp;
        Start  = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge Clk);
            if (c == 1) Start = 1'b0;
            if (LoadRegs && load_cyc < 0) load_cyc = c;
            n_add   += int'(AddEn);
            n_shift += int'(ShiftEn);
            if (Done) begin
                done_cyc  = c;
                iter_done = int'(Iter);
                break;
            end
        end
    endtask

    int ld, dn, na, ns, it;
    int nd;
    logic [29:0] log_busy, log_load, log_done;

    initial begin
        rst = 1'b1; Start = 1'b0; Abort = 1'b0; mplier = '0;
        repeat (2) @(negedge Clk);
        chk_vec("reset_outs", outs_word(), 0);
        chk_vec("reset_iter", int'(Iter), 0);
        rst = 1'b0;
        @(negedge Clk);
        chk_vec("idle_outs", outs_word(), 0);

        // 1011: P=3 -> Done at 2+8+3 = 13.
        run_op(4'b1011, 40, ld, dn, na, ns, it);
        chk_vec("b1011_load_cyc", ld, 1);
        chk_vec("b1011_adds", na, 3);
        chk_vec("b1011_shifts", ns, 4);
        chk_vec("b1011_done_cyc", dn, 13);
        chk_vec("b1011_iter", it, 4);
        @(negedge Clk);
        chk_vec("b1011_idle_after", outs_word(), 0);
        chk_vec("b1011_iter_hold", int'(Iter), 4);

        // 1000: P=1 -> Done at 11.
        run_op(4'b1000, 40, ld, dn, na, ns, it);
        chk_vec("b1000_adds", na, 1);
        chk_vec("b1000_done_cyc", dn, 11);
        chk_vec("b1000_iter", it, 4);

        // Multiplier 0.
        run_op(4'b0000, 40, ld, dn, na, ns, it);
        chk_vec("zero_adds", na, 0);
`ifdef EARLY_EXIT_EN
        chk_vec("zero_done_cyc", dn, 3);
        chk_vec("zero_shifts", ns, 0);
        chk_vec("zero_iter", it, 0);
`else
        chk_vec("zero_done_cyc", dn, 10);
        chk_vec("zero_shifts", ns, 4);
        chk_vec("zero_iter", it, 4);
`endif

        // Start re-pulsed while Busy, Abort in the 2nd CHECK (cycle 5).
        @(negedge Clk);
        mplier = 4'b1011;
        Start  = 1'b1;
        @(negedge Clk);                 // cycle 1: LOAD
        Start = 1'b0;
        chk_vec("abort_load", int'(LoadRegs), 1);
        @(negedge Clk);                 // cycle 2: CHECK
        chk_vec("abort_iter_cleared", int'(Iter), 0);
        @(negedge Clk);                 // cycle 3: ADD
        Start = 1'b1;
        @(negedge Clk);                 // cycle 4: SHIFT
        Start = 1'b0;
        chk_vec("abort_shift", int'(ShiftEn), 1);
        @(negedge Clk);                 // cycle 5: 2nd CHECK
        chk_vec("abort_check_busy", int'(Busy), 1);
        chk_vec("abort_check_iter", int'(Iter), 1);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk_vec("abort_outs", outs_word(), 0);
        chk_vec("abort_iter", int'(Iter), 0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            nd += int'(Done) + int'(LoadRegs);
        end
        chk_vec("abort_no_done_no_restart", nd, 0);

        // Start and Abort together in IDLE: stay idle.
        Start = 1'b1; Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        chk_vec("start_abort_idle", outs_word(), 0);

        // Asynchronous reset in SHIFT (cycle 4 of a 1011 operation).
        @(negedge Clk);
        mplier = 4'b1011;
        Start  = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk_vec("rst_in_shift", int'(ShiftEn), 1);
        #1 rst = 1'b1;
        #1;
        chk_vec("rst_async_outs", outs_word(), 0);
        chk_vec("rst_async_iter", int'(Iter), 0);
        @(negedge Clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            nd += int'(Done) + int'(Busy);
        end
        chk_vec("rst_no_done", nd, 0);

        // Start held high for 30 cycles with 1111: Done at 14, IDLE at 15,
        // LOAD at 16, second Done at 15+14 = 29.
        @(negedge Clk);
        mplier = 4'b1111;
        Start  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            log_busy[c-1] = Busy;
            log_load[c-1] = LoadRegs;
            log_done[c-1] = Done;
        end
        Start = 1'b0;
        chk_vec("held_first_done", int'(log_done[13]), 1);
        chk_vec("held_done_count", $countones(log_done), 2);
        chk_vec("held_idle_gap", int'(log_busy[14]), 0);
        chk_vec("held_reload", int'(log_load[15]), 1);
        chk_vec("held_second_done", int'(log_done[28]), 1);
        chk_vec("held_busy_cycles", $countones(log_busy), 28);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
